// File: rtl/vend_sequencer.sv
// vend_sequencer: vending transaction controller.
// Accumulates coin credit, vends a selected slot when credit covers its price,
// then pays change back one coin at a time over an eject_req/eject_ack handshake.
// Optional feature macro: VEND_TIMEOUT_EN (idle auto-refund after TIMEOUT_CYCLES).
module vend_sequencer #(
  parameter int unsigned CREDIT_W       = 8,
  parameter int unsigned PRICE0         = 15,
  parameter int unsigned PRICE1         = 20,
  parameter int unsigned PRICE2         = 25,
  parameter int unsigned PRICE3         = 30,
  parameter int unsigned MOTOR_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                sel_valid,
  input  logic [1:0]          sel_id,
  input  logic                cancel,
  input  logic                eject_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                motor_on,
  output logic [1:0]          motor_slot,
  output logic                eject_req,
  output logic                eject_coin,
  output logic                coin_reject,
  output logic                err_insuff,
  output logic                busy
);

  localparam int unsigned CW1   = CREDIT_W + 1;
  localparam int unsigned MOT_W = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;
  localparam logic [CW1-1:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [MOT_W-1:0] MOT_LAST   = MOT_W'(MOTOR_CYCLES - 1);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit_nx;
  logic                motor_on_nx, eject_req_nx, eject_coin_nx;
  logic [1:0]          motor_slot_nx;
  logic                coin_reject_nx, err_insuff_nx, busy_nx;
  logic [MOT_W-1:0]    mot_cnt, mot_cnt_nx;

  logic                coin_present, sel_ok, coin_fits;
  logic [CW1-1:0]      coin_val, price, base, sum;
  logic                timeout_hit;

  // Credit arithmetic for COLLECT: selection is judged on registered credit, coin is added on top.
  always_comb begin
    coin_present = coin_valid && (coin_code != 2'b00);
    coin_val     = '0;
    case (coin_code)
      2'b01:   coin_val = CW1'(5);
      2'b10:   coin_val = CW1'(10);
      2'b11:   coin_val = CW1'(20);
      default: coin_val = '0;
    endcase
    price = '0;
    case (sel_id)
      2'd0:    price = CW1'(PRICE0);
      2'd1:    price = CW1'(PRICE1);
      2'd2:    price = CW1'(PRICE2);
      default: price = CW1'(PRICE3);
    endcase
    sel_ok    = sel_valid && ({1'b0, credit} >= price);
    base      = sel_ok ? ({1'b0, credit} - price) : {1'b0, credit};
    sum       = base + coin_val;
    coin_fits = coin_present && (sum <= CREDIT_MAX);
  end

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt, idle_cnt_nx;

  // Idle counter: runs only while credit sits untouched in COLLECT.
  always_comb begin
    idle_cnt_nx = '0;
    timeout_hit = 1'b0;
    if (state == COLLECT && !(coin_fits || sel_valid || cancel) && credit != '0) begin
      if (idle_cnt == IDLE_LAST) begin
        timeout_hit = 1'b1;
      end else begin
        idle_cnt_nx = idle_cnt + 1'b1;
      end
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt <= '0;
    else        idle_cnt <= idle_cnt_nx;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx       = state;
    credit_nx      = credit;
    motor_on_nx    = motor_on;
    motor_slot_nx  = motor_slot;
    eject_req_nx   = eject_req;
    eject_coin_nx  = eject_coin;
    coin_reject_nx = 1'b0;
    err_insuff_nx  = 1'b0;
    mot_cnt_nx     = mot_cnt;
    case (state)
      COLLECT: begin
        credit_nx = coin_fits ? sum[CREDIT_W-1:0] : base[CREDIT_W-1:0];
        if (coin_present && !coin_fits) coin_reject_nx = 1'b1;
        if (sel_valid) begin
          if (sel_ok) begin
            motor_slot_nx = sel_id;
            motor_on_nx   = 1'b1;
            mot_cnt_nx    = '0;
            state_nx      = VEND;
          end else begin
            err_insuff_nx = 1'b1;
          end
        end else if ((cancel && credit != '0) || timeout_hit) begin
          // Refund starts with the credit as it stands after this cycle's coin.
          state_nx      = CHANGE;
          eject_req_nx  = 1'b1;
          eject_coin_nx = (credit_nx >= CREDIT_W'(10));
        end
      end
      VEND: begin
        if (coin_present) coin_reject_nx = 1'b1;
        if (mot_cnt == MOT_LAST) begin
          motor_on_nx = 1'b0;
          if (credit != '0) begin
            state_nx      = CHANGE;
            eject_req_nx  = 1'b1;
            eject_coin_nx = (credit >= CREDIT_W'(10));
          end else begin
            state_nx = COLLECT;
          end
        end else begin
          mot_cnt_nx = mot_cnt + 1'b1;
        end
      end
      CHANGE: begin
        if (coin_present) coin_reject_nx = 1'b1;
        if (eject_req) begin
          if (eject_ack) begin
            credit_nx    = credit - (eject_coin ? CREDIT_W'(10) : CREDIT_W'(5));
            eject_req_nx = 1'b0;
            if (credit_nx == '0) state_nx = COLLECT;
          end
        end else begin
          eject_req_nx  = 1'b1;
          eject_coin_nx = (credit >= CREDIT_W'(10));
        end
      end
      default: state_nx = COLLECT;
    endcase
    busy_nx = (state_nx != COLLECT);
  end

  // State and output registers; asynchronous reset drops motor and ejector at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      credit      <= '0;
      motor_on    <= 1'b0;
      motor_slot  <= 2'b00;
      eject_req   <= 1'b0;
      eject_coin  <= 1'b0;
      coin_reject <= 1'b0;
      err_insuff  <= 1'b0;
      busy        <= 1'b0;
      mot_cnt     <= '0;
    end else begin
      state       <= state_nx;
      credit      <= credit_nx;
      motor_on    <= motor_on_nx;
      motor_slot  <= motor_slot_nx;
      eject_req   <= eject_req_nx;
      eject_coin  <= eject_coin_nx;
      coin_reject <= coin_reject_nx;
      err_insuff  <= err_insuff_nx;
      busy        <= busy_nx;
      mot_cnt     <= mot_cnt_nx;
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed vectors with hand-computed expectations for vend_sequencer.
// Timeout scenario is exercised when built with VEND_TIMEOUT_EN.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid, sel_valid, cancel, eject_ack;
  logic [1:0] coin_code, sel_id;
  logic [7:0] credit;
  logic       motor_on, eject_req, eject_coin, coin_reject, err_insuff, busy;
  logic [1:0] motor_slot;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  vend_sequencer #(
    .CREDIT_W(8), .PRICE0(15), .PRICE1(20), .PRICE2(25), .PRICE3(30),
    .MOTOR_CYCLES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_code(coin_code),
    .sel_valid(sel_valid), .sel_id(sel_id),
    .cancel(cancel), .eject_ack(eject_ack),
    .credit(credit), .motor_on(motor_on), .motor_slot(motor_slot),
    .eject_req(eject_req), .eject_coin(eject_coin),
    .coin_reject(coin_reject), .err_insuff(err_insuff), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] code);
    coin_valid = 1'b1; coin_code = code;
    step();
    coin_valid = 1'b0; coin_code = 2'b00;
  endtask

  // Count cycles motor_on stays high (bounded).
  task automatic motor_run(output int unsigned n);
    n = 0;
    while (motor_on && n < 20) begin
      n++;
      step();
    end
  endtask

  // Wait for a change request, acknowledge it for `hold` cycles, return its coin.
  task automatic eject_one(input string tag, input int unsigned hold, output logic c);
    int unsigned w = 0;
    while (!eject_req && w < 10) begin
      w++;
      step();
    end
    check({tag, "_req_seen"}, eject_req, 1);
    c = eject_coin;
    eject_ack = 1'b1;
    for (int unsigned i = 0; i < hold; i++) step();
    eject_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        c;
    int unsigned n, v, fives;

    rst_n = 1'b0; coin_valid = 1'b0; coin_code = 2'b00;
    sel_valid = 1'b0; sel_id = 2'b00; cancel = 1'b0; eject_ack = 1'b0;
    step(); step();
    check("rst_credit", credit, 0);
    check("rst_motor", motor_on, 0);
    check("rst_eject", eject_req, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // 1: 10+10, buy slot 0 (15), one 5-coin back.
    coin(2'b10); coin(2'b10);
    check("t1_credit20", credit, 20);
    sel_valid = 1'b1; sel_id = 2'd0; step(); sel_valid = 1'b0;
    check("t1_motor_on", motor_on, 1);
    check("t1_slot", motor_slot, 0);
    check("t1_credit5", credit, 5);
    check("t1_busy", busy, 1);
    motor_run(n);
    check("t1_motor_cycles", n, 4);
    check("t1_eject_req", eject_req, 1);
    check("t1_eject_coin", eject_coin, 0);
    eject_one("t1", 1, c);
    check("t1_credit0", credit, 0);
    check("t1_req_drop", eject_req, 0);
    check("t1_idle", busy, 0);

    // 2: credit 5, slot 1 (20) -> insufficient.
    coin(2'b01);
    sel_valid = 1'b1; sel_id = 2'd1; step(); sel_valid = 1'b0;
    check("t2_err_insuff", err_insuff, 1);
    check("t2_credit", credit, 5);
    check("t2_busy", busy, 0);
    step();
    check("t2_err_pulse", err_insuff, 0);
    cancel = 1'b1; step(); cancel = 1'b0;
    eject_one("t2", 1, c);
    check("t2_coin5", c, 0);
    check("t2_empty", credit, 0);

    // 3: credit 40, cancel -> four 10s; coin during CHANGE rejected; ack held while req low ignored.
    coin(2'b11); coin(2'b11);
    check("t3_credit40", credit, 40);
    cancel = 1'b1; step(); cancel = 1'b0;
    check("t3_busy", busy, 1);
    check("t3_coin10", eject_coin, 1);
    coin(2'b01);
    check("t3_reject_change", coin_reject, 1);
    check("t3_credit_kept", credit, 40);
    eject_one("t3a", 2, c);
    check("t3_ack_ignored", credit, 30);
    for (int unsigned k = 0; k < 3; k++) begin
      eject_one("t3b", 1, c);
      check("t3_coin_is10", c, 1);
    end
    check("t3_credit0", credit, 0);
    check("t3_not_busy", busy, 0);

    // 4: saturation boundary at 255 and coin during VEND.
    for (int unsigned k = 0; k < 12; k++) coin(2'b11);
    coin(2'b10);
    check("t4_credit250", credit, 250);
    coin(2'b11);
    check("t4_reject_ovf", coin_reject, 1);
    check("t4_credit_hold", credit, 250);
    step();
    check("t4_reject_pulse", coin_reject, 0);
    coin(2'b01);
    check("t4_credit255", credit, 255);
    check("t4_accept_max", coin_reject, 0);
    coin(2'b01);
    check("t4_reject_260", coin_reject, 1);
    sel_valid = 1'b1; sel_id = 2'd3; step(); sel_valid = 1'b0;
    check("t4_slot3", motor_slot, 3);
    check("t4_credit225", credit, 225);
    coin(2'b01);
    check("t4_reject_vend", coin_reject, 1);
    check("t4_credit_vend", credit, 225);
    motor_run(n);
    check("t4_motor_cycles", n, 3);
    v = 0; fives = 0; n = 0;
    while (busy && n < 40) begin
      eject_one("t4", 1, c);
      v += c ? 10 : 5;
      if (!c) fives++;
      n++;
    end
    check("t4_refund_total", v, 225);
    check("t4_fives", fives, 1);
    check("t4_last5", c, 0);

    // 5: credit 10, coin 5 + sel 0 together -> insufficient, coin kept; then vend to zero.
    coin(2'b10);
    coin_valid = 1'b1; coin_code = 2'b01; sel_valid = 1'b1; sel_id = 2'd0;
    step();
    coin_valid = 1'b0; coin_code = 2'b00; sel_valid = 1'b0;
    check("t5_err_insuff", err_insuff, 1);
    check("t5_credit15", credit, 15);
    sel_valid = 1'b1; step(); sel_valid = 1'b0;
    check("t5_vend", motor_on, 1);
    check("t5_credit0", credit, 0);
    motor_run(n);
    check("t5_motor_cycles", n, 4);
    check("t5_no_change", eject_req, 0);
    check("t5_idle", busy, 0);

    // 7: sel wins over cancel, with same-cycle coin: 20 - 15 + 10 = 15.
    coin(2'b11);
    coin_valid = 1'b1; coin_code = 2'b10; sel_valid = 1'b1; sel_id = 2'd0; cancel = 1'b1;
    step();
    coin_valid = 1'b0; coin_code = 2'b00; sel_valid = 1'b0; cancel = 1'b0;
    check("t7_vend", motor_on, 1);
    check("t7_credit15", credit, 15);
    check("t7_no_eject", eject_req, 0);
    motor_run(n);
    eject_one("t7a", 1, c);
    check("t7_first10", c, 1);
    eject_one("t7b", 1, c);
    check("t7_then5", c, 0);
    check("t7_done", busy, 0);

    // 6: idle behaviour, then reset mid-CHANGE.
    coin(2'b10);
`ifdef VEND_TIMEOUT_EN
    n = 0;
    while (!eject_req && n < 40) begin
      n++;
      step();
    end
    check("t6_timeout_cycles", n, 16);
    check("t6_timeout_coin", eject_coin, 1);
`else
    for (int unsigned k = 0; k < 40; k++) step();
    check("t6_no_timeout", eject_req, 0);
    check("t6_credit_held", credit, 10);
    cancel = 1'b1; step(); cancel = 1'b0;
    check("t6_change", eject_req, 1);
`endif
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_req", eject_req, 0);
    check("t6_async_credit", credit, 0);
    check("t6_async_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();
    check("t6_after_rst", eject_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
